// File: rtl/alu_arith_arbiter_if.sv
// Client, ALU and response bundle for alu_arith_arbiter.
// slave = arbiter side, master = clients/ALU/response consumer side.
interface alu_arith_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_opcode;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [3:0]           alu_opcode;
  logic [15:0]          alu_a;
  logic [15:0]          alu_b;
  logic [15:0]          alu_out;
  logic                 alu_carry;
  logic                 alu_overflow;
  logic                 alu_sign;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_out;
  logic                 rsp_carry;
  logic                 rsp_overflow;
  logic                 rsp_sign;
  logic                 rsp_err;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b,
    input  alu_out, alu_carry, alu_overflow, alu_sign,
    input  rsp_ready,
    output req_ready,
    output alu_opcode, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_overflow, rsp_sign, rsp_err
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b,
    output alu_out, alu_carry, alu_overflow, alu_sign,
    output rsp_ready,
    input  req_ready,
    input  alu_opcode, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_overflow, rsp_sign, rsp_err
  );
endinterface

// File: rtl/alu_arith_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit add/sub ALU among NREQ clients.
// Optional ALU_ARB_STATS_EN adds saturating stat_ops / stat_errs counters.
module alu_arith_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_arith_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_errs
`endif
);

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_NOP = 4'b0000;
  localparam logic [OPW-1:0] OP_ADD = 4'b0100;
  localparam logic [OPW-1:0] OP_SUB = 4'b0101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [OPW-1:0]  alu_opcode_q, alu_opcode_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_out_q, rsp_out_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_overflow_q, rsp_overflow_d;
  logic            rsp_sign_q, rsp_sign_d;
  logic            rsp_err_q, rsp_err_d;

  logic            win_found_c;
  logic [IDW-1:0]  win_idx_c;
  logic [OPW-1:0]  win_op_c;
  logic [DW-1:0]   win_a_c;
  logic [DW-1:0]   win_b_c;
  logic            win_legal_c;
  logic            accept_c;

  // Rotating priority scan starting at rr_ptr
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned cand;
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found_c && bus.req_valid[IDW'(cand)]) begin
        win_found_c = 1'b1;
        win_idx_c   = IDW'(cand);
      end
    end
  end

  assign win_op_c    = bus.req_opcode[{win_idx_c, 2'b00} +: OPW];
  assign win_a_c     = bus.req_a[{win_idx_c, 4'b0000} +: DW];
  assign win_b_c     = bus.req_b[{win_idx_c, 4'b0000} +: DW];
  assign win_legal_c = (win_op_c == OP_ADD) || (win_op_c == OP_SUB);
  assign accept_c    = (state_q == S_IDLE) && win_found_c;

  always_comb begin
    bus.req_ready = '0;
    if (accept_c) bus.req_ready = NREQ'(1) << win_idx_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    alu_opcode_d   = alu_opcode_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_out_d      = rsp_out_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_sign_d     = rsp_sign_q;
    rsp_err_d      = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found_c) begin
          id_d     = win_idx_c;
          rr_ptr_d = (win_idx_c == IDW'(NREQ - 1)) ? '0 : win_idx_c + IDW'(1);
          if (win_legal_c) begin
            alu_opcode_d = win_op_c;
            alu_a_d      = win_a_c;
            alu_b_d      = win_b_c;
            state_d      = S_ISSUE;
          end else begin
            // Illegal opcode: answer immediately, ALU stays idle
            rsp_valid_d    = 1'b1;
            rsp_id_d       = win_idx_c;
            rsp_out_d      = '0;
            rsp_carry_d    = 1'b0;
            rsp_overflow_d = 1'b0;
            rsp_sign_d     = 1'b0;
            rsp_err_d      = 1'b1;
            state_d        = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        alu_opcode_d = OP_NOP;
        state_d      = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_valid_d    = 1'b1;
        rsp_id_d       = id_q;
        rsp_out_d      = bus.alu_out;
        rsp_carry_d    = bus.alu_carry;
        rsp_overflow_d = bus.alu_overflow;
        rsp_sign_d     = bus.alu_sign;
        rsp_err_d      = 1'b0;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      id_q           <= '0;
      alu_opcode_q   <= OP_NOP;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_out_q      <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_sign_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_out_q      <= rsp_out_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_sign_q     <= rsp_sign_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_out      = rsp_out_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_sign     = rsp_sign_q;
  assign bus.rsp_err      = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  // Saturating accept counters, split by opcode legality
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (accept_c) begin
      if (win_legal_c) begin
        if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      end else begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arith_arbiter.sv
// Directed self-checking bench for alu_arith_arbiter with a registered ALU model.
module tb_alu_arith_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arith_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  alu_arith_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
`endif
  );

  // Registered ALU model; idle cycles produce poison so mistimed sampling is visible
  logic [16:0] alu_sum;
  always_comb begin
    if (bus.alu_opcode == OP_SUB) alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
    else                          alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  end
  always_ff @(posedge clk) begin
    if (bus.alu_opcode == OP_ADD || bus.alu_opcode == OP_SUB) begin
      bus.alu_out      <= alu_sum[15:0];
      bus.alu_carry    <= alu_sum[16];
      bus.alu_sign     <= alu_sum[15];
      if (bus.alu_opcode == OP_ADD)
        bus.alu_overflow <= (bus.alu_a[15] == bus.alu_b[15]) && (alu_sum[15] != bus.alu_a[15]);
      else
        bus.alu_overflow <= (bus.alu_a[15] != bus.alu_b[15]) && (alu_sum[15] != bus.alu_a[15]);
    end else begin
      bus.alu_out      <= 16'hDEAD;
      bus.alu_carry    <= 1'b1;
      bus.alu_overflow <= 1'b1;
      bus.alu_sign     <= 1'b1;
    end
  end

  typedef struct {
    int         port;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic       c;
    logic       v;
    logic       s;
    logic       err;
  } vec_t;

  vec_t vecs [7];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[p]        = 1'b1;
    bus.req_opcode[p*4 +: 4] = op;
    bus.req_a[p*16 +: 16]    = a;
    bus.req_b[p*16 +: 16]    = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, nz, gcount, last_cyc, seen;
    logic [3:0] first_op;
    logic [15:0] first_a, hold_out;
    logic [IDW-1:0] hold_id;
    int exp_order [5];

    vecs[0] = '{2, OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{0, OP_SUB,  16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1, 4'b0110, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3, OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1, OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{0, OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{2, 4'b0000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    tick(); tick();
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    chk("reset_rsp_out", 32'(bus.rsp_out), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk("grant_onehot", 32'(bus.req_ready), 32'(1) << vecs[i].port);
      tick();
      clear_reqs();
      cnt = 1; nz = 0;
      first_op = bus.alu_opcode; first_a = bus.alu_a;
      while (!bus.rsp_valid && cnt < 10) begin
        if (bus.alu_opcode != 4'd0) nz++;
        tick();
        cnt++;
      end
      chk("latency", 32'(cnt), vecs[i].err ? 32'd1 : 32'd3);
      chk("alu_drive_cycles", 32'(nz), vecs[i].err ? 32'd0 : 32'd1);
      if (!vecs[i].err) begin
        chk("issue_opcode", 32'(first_op), 32'(vecs[i].op));
        chk("issue_a", 32'(first_a), 32'(vecs[i].a));
      end
      chk("rsp_id", 32'(bus.rsp_id), 32'(vecs[i].port));
      chk("rsp_out", 32'(bus.rsp_out), 32'(vecs[i].out));
      chk("rsp_err_c_v_s", {28'd0, bus.rsp_err, bus.rsp_carry, bus.rsp_overflow, bus.rsp_sign},
          {28'd0, vecs[i].err, vecs[i].c, vecs[i].v, vecs[i].s});
      tick();
      chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    end
`ifdef ALU_ARB_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'd5);
    chk("stat_errs", 32'(stat_errs), 32'd2);
`endif

    // Round robin with all requesters active
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int p = 0; p < 4; p++) set_req(p, OP_ADD, 16'(p), 16'd1);
    #1;
    gcount = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40 && gcount < 5; cyc++) begin
      if (bus.req_ready != '0) begin
        chk("rr_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        chk("rr_order", 32'(bus.req_ready), 32'(1) << exp_order[gcount]);
        if (gcount > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        gcount++;
      end
      tick();
    end
    chk("rr_grants", 32'(gcount), 32'd5);
    clear_reqs();
    repeat (5) tick();

    // Response backpressure
    bus.rsp_ready = 1'b0;
    set_req(1, OP_ADD, 16'd1, 16'd2);
    #1;
    tick();
    clear_reqs();
    cnt = 0;
    while (!bus.rsp_valid && cnt < 10) begin tick(); cnt++; end
    chk("bp_rsp_out", 32'(bus.rsp_out), 32'd3);
    hold_out = bus.rsp_out; hold_id = bus.rsp_id;
    set_req(0, OP_ADD, 16'd7, 16'd7);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_stable", {15'd0, bus.rsp_valid, bus.rsp_out}, {15'd0, 1'b1, hold_out});
      chk("bp_id", 32'(bus.rsp_id), 32'(hold_id));
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_release_idle", 32'(bus.req_ready), 32'b0001);
    clear_reqs();
    tick();

    // Reset during CAPTURE drops the transaction
    set_req(1, OP_ADD, 16'd10, 16'd20);
    #1;
    tick();
    clear_reqs();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_opcode", 32'(bus.alu_opcode), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_stat_ops", 32'(stat_ops), 32'd0);
    chk("rst_stat_errs", 32'(stat_errs), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.rsp_valid) seen = 1;
    end
    chk("rst_no_rsp", 32'(seen), 32'd0);
    for (int p = 0; p < 4; p++) set_req(p, OP_ADD, 16'd0, 16'd0);
    #1;
    chk("rst_rr_ptr", 32'(bus.req_ready), 32'b0001);
    clear_reqs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
